seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Multi-cycle unsigned restoring divider: the inverse of the adder chain, built from
//   repeated trial subtraction (one per cycle) with shift. Accepts a dividend/divisor
//   pair on a start pulse and returns quotient, remainder and a divide-by-zero flag.
//   Sits beside the ripple adders in the arithmetic fundamentals library as the first
//   sequential datapath block.
// PARAMETERS
//   WIDTH  16  operand, quotient and remainder width in bits (>= 2)
// PORTS
//   clk          in   1      single clock; all state changes on rising edge
//   rst          in   1      synchronous, active-high reset
//   start        in   1      request; sampled only when busy == 0
//   dividend     in   WIDTH  unsigned numerator, captured on an accepted start
//   divisor      in   WIDTH  unsigned denominator, captured on an accepted start
//   busy         out  1      1 while a division is in progress
//   done         out  1      one-cycle pulse: results valid from this cycle on
//   quotient     out  WIDTH  result, held until the next completion
//   remainder    out  WIDTH  result, held until the next completion
//   div_by_zero  out  1      set with done when divisor was 0; held like results
// BEHAVIOUR
//   - Reset (rst=1 at an edge): state IDLE, busy=0, done=0, quotient=0, remainder=0,
//     div_by_zero=0, iteration counter=0. Reset mid-operation aborts; no done pulse.
//   - States: IDLE, RUN. IDLE->RUN on start with divisor!=0; RUN->IDLE after WIDTH
//     iterations. Start with divisor==0 stays in IDLE (fast path).
//   - Accept: start=1 in cycle t with busy=0. Operands are latched at edge t.
//   - Normal latency: busy=1 in cycles t+1..t+WIDTH (one iteration per cycle); results
//     registered at edge t+WIDTH; done=1 and busy=0 in cycle t+WIDTH+1.
//   - Divide-by-zero: no RUN; done=1 in cycle t+1 with quotient={WIDTH{1'b1}},
//     remainder=dividend, div_by_zero=1. busy stays 0.
//   - Iteration (restoring): partial remainder R is WIDTH+1 bits, Q is a WIDTH-bit shift
//     register loaded with the dividend, R cleared at accept.
//     R' = {R[WIDTH-1:0], Q[WIDTH-1]}; T = R' - {1'b0, divisor};
//     if T[WIDTH]==0 then R=T, Q={Q[WIDTH-2:0],1} else R=R', Q={Q[WIDTH-2:0],0}.
//     Final quotient=Q, remainder=R[WIDTH-1:0]. Guarantees remainder < divisor.
//   - start while busy=1 is ignored (no queueing, operands not resampled).
//   - start in the done cycle (busy=0) is accepted: back-to-back throughput is one
//     result per WIDTH+1 cycles.
//   - done is asserted for exactly one cycle per accepted start, never otherwise.
//   - quotient/remainder/div_by_zero change only at the edge that raises done (or reset);
//     a normal completion clears div_by_zero to 0.
//   - dividend/divisor inputs are don't-care outside the accept cycle.
// TESTING (WIDTH=16 unless noted; t = cycle start is accepted)
//   1 100/7 -> busy cycles t+1..t+16, done in t+17: quotient=14, remainder=2, dbz=0.
//   2 1234/0 -> done in t+1, busy never 1: quotient=0xFFFF, remainder=1234, dbz=1;
//     then 9/3 -> done at t'+17, quotient=3, remainder=0, dbz cleared.
//   3 Corners: 0xFFFF/1 -> q=0xFFFF,r=0; 5/9 -> q=0,r=5; 0xFFFF/0xFFFF -> q=1,r=0;
//     0/0x0001 -> q=0,r=0.
//   4 Start 50/5, re-pulse start with 77/3 at t+4: ignored; done once at t+17 with
//     q=10,r=0; no second done.
//   5 Start 1000/3, rst=1 in t+6: busy=0 and all outputs 0 from t+7, no done pulse;
//     next 8/2 completes normally with q=4,r=0.
//   6 Back-to-back: start 200/9 then start 31/4 held in its done cycle -> done pulses at
//     t+17 (q=22,r=2) and t+34 (q=7,r=3). Random 2000-pair self-check vs a/b, a%b.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per cycle, WIDTH cycles per result.
// A zero divisor completes on the next cycle with an all-ones quotient and the dividend as remainder.
module seq_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    // The stored partial remainder is always < divisor, so only the shifted value needs the extra bit.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        rem_shift = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvs_q};

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (divisor_i == '0) begin
                        done_d      = 1'b1;
                        quotient_d  = '1;
                        remainder_d = dividend_i;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = StRun;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = dividend_i;
                        dvs_d   = divisor_i;
                    end
                end
            end
            StRun: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d     = StIdle;
                    cnt_d       = '0;
                    done_d      = 1'b1;
                    quotient_d  = quo_d;
                    remainder_d = rem_d;
                    dbz_d       = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign busy_o        = (state_q == StRun);
    assign done_o        = done_q;
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vectors with hand-computed results,
// cycle-exact handshake checks, reset abort, back-to-back and a random sweep.
module tb_seq_divider;

    localparam int unsigned WIDTH = 16;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;
    logic             div_by_zero_o;

    int n_checks = 0;
    int n_errors = 0;

    seq_divider #(.WIDTH(WIDTH)) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .dividend_i   (dividend_i),
        .divisor_i    (divisor_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .quotient_o   (quotient_o),
        .remainder_o  (remainder_o),
        .div_by_zero_o(div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Accept a/b in the current cycle, wait for done, check latency, busy span and results.
    task automatic run_div(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] exp_q, input logic [WIDTH-1:0] exp_r,
                           input logic exp_dbz);
        int lat;
        int busy_cnt;
        int exp_lat;
        exp_lat    = (b == '0) ? 1 : WIDTH + 1;
        start_i    = 1'b1;
        dividend_i = a;
        divisor_i  = b;
        tick();
        start_i    = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        lat        = 1;
        busy_cnt   = 0;
        while (!done_o && lat < 40) begin
            if (busy_o) busy_cnt++;
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy cycles"}, busy_cnt, exp_lat - 1);
        check({tag, " busy in done"}, busy_o, 1'b0);
        check({tag, " quotient"}, quotient_o, exp_q);
        check({tag, " remainder"}, remainder_o, exp_r);
        check({tag, " dbz"}, div_by_zero_o, exp_dbz);
        tick();
        check({tag, " done width"}, done_o, 1'b0);
    endtask

    initial begin
        rst_i      = 1'b1;
        start_i    = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        tick();
        tick();
        rst_i = 1'b0;
        check("reset busy", busy_o, 1'b0);
        check("reset done", done_o, 1'b0);
        check("reset quotient", quotient_o, 0);
        check("reset remainder", remainder_o, 0);
        check("reset dbz", div_by_zero_o, 1'b0);

        run_div("100/7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        run_div("1234/0", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1);
        run_div("9/3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0);
        run_div("FFFF/1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
        run_div("5/9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0);
        run_div("FFFF/FFFF", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
        run_div("0/1", 16'd0, 16'd1, 16'd0, 16'd0, 1'b0);

        // start re-pulsed while busy is ignored: one done at t+17 with 50/5
        for (int c = 0; c <= 22; c++) begin
            start_i    = (c == 0) || (c == 4);
            dividend_i = (c == 0) ? 16'd50 : (c == 4) ? 16'd77 : 16'd0;
            divisor_i  = (c == 0) ? 16'd5 : (c == 4) ? 16'd3 : 16'd0;
            if (c > 0) begin
                check($sformatf("ignore busy c%0d", c), busy_o, (c >= 1 && c <= 16));
                check($sformatf("ignore done c%0d", c), done_o, (c == 17));
            end
            if (c == 17) begin
                check("ignore quotient", quotient_o, 16'd10);
                check("ignore remainder", remainder_o, 16'd0);
            end
            tick();
        end
        start_i = 1'b0;

        // reset mid-run aborts with no done pulse
        for (int c = 0; c <= 20; c++) begin
            start_i    = (c == 0);
            dividend_i = (c == 0) ? 16'd1000 : 16'd0;
            divisor_i  = (c == 0) ? 16'd3 : 16'd0;
            rst_i      = (c == 6);
            if (c >= 7) begin
                check($sformatf("abort busy c%0d", c), busy_o, 1'b0);
                check($sformatf("abort done c%0d", c), done_o, 1'b0);
            end
            if (c == 7) begin
                check("abort quotient", quotient_o, 0);
                check("abort remainder", remainder_o, 0);
                check("abort dbz", div_by_zero_o, 1'b0);
            end
            tick();
        end
        rst_i   = 1'b0;
        start_i = 1'b0;
        run_div("8/2", 16'd8, 16'd2, 16'd4, 16'd0, 1'b0);

        // back-to-back: second start accepted in the first done cycle
        for (int c = 0; c <= 36; c++) begin
            start_i    = (c == 0) || (c == 17);
            dividend_i = (c == 0) ? 16'd200 : (c == 17) ? 16'd31 : 16'd0;
            divisor_i  = (c == 0) ? 16'd9 : (c == 17) ? 16'd4 : 16'd0;
            if (c > 0) check($sformatf("b2b done c%0d", c), done_o, (c == 17) || (c == 34));
            if (c == 17) begin
                check("b2b q1", quotient_o, 16'd22);
                check("b2b r1", remainder_o, 16'd2);
            end
            if (c == 34) begin
                check("b2b q2", quotient_o, 16'd7);
                check("b2b r2", remainder_o, 16'd3);
                check("b2b dbz2", div_by_zero_o, 1'b0);
            end
            tick();
        end
        start_i = 1'b0;

        for (int i = 0; i < 2000; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            a = WIDTH'($urandom);
            b = (i % 50 == 0) ? '0 : (i % 3 == 0) ? WIDTH'($urandom_range(1, 255))
                                                  : WIDTH'($urandom);
            if (b == '0) run_div($sformatf("rnd%0d", i), a, b, '1, a, 1'b1);
            else         run_div($sformatf("rnd%0d", i), a, b, a / b, a % b, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
